sbilinear_sched: RTL and testbench

- Frame-level sequencer for the shift-based bilinear interpolator datapath (1-cycle `valid_in`→`valid_out`, four signed samples, four shift codes).
- For every output pixel of a WxH tile it fetches the 2x2 neighbourhood from a single-port sample RAM, clamping at the tile edges.
- It issues one datapath operation per pixel and returns results on a valid/ready stream.
- Shift codes are per-job: a uniform sub-pixel offset, as used in motion compensation.

---
 rtl/sbilinear_sched.sv | 214 +++++++++++++++++++++
 tb/tb_sbilinear_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbilinear_sched.sv
// Frame sequencer for the shift-based bilinear datapath.
// Fetches clamped 2x2 neighbourhoods, issues one op per pixel, streams results.
module sbilinear_sched #(
   parameter int DATA_W = 16,
   parameter int SHW    = 6,
   parameter int ADDR_W = 12,
   parameter int DIM_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [DIM_W-1:0]  cfg_stride,
   input  logic [DIM_W-1:0]  cfg_width,
   input  logic [DIM_W-1:0]  cfg_height,
   input  logic [SHW-1:0]    cfg_s0,
   input  logic [SHW-1:0]    cfg_s1,
   input  logic [SHW-1:0]    cfg_s2,
   input  logic [SHW-1:0]    cfg_s3,
   output logic              busy,
   output logic              done,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              dp_valid_in,
   output logic [DATA_W-1:0] dp_v00,
   output logic [DATA_W-1:0] dp_v01,
   output logic [DATA_W-1:0] dp_v10,
   output logic [DATA_W-1:0] dp_v11,
   output logic [SHW-1:0]    dp_s0,
   output logic [SHW-1:0]    dp_s1,
   output logic [SHW-1:0]    dp_s2,
   output logic [SHW-1:0]    dp_s3,
   input  logic [DATA_W-1:0] dp_out,
   input  logic              dp_valid_out,
   output logic              o_valid,
   input  logic              o_ready,
   output logic [DATA_W-1:0] o_data,
   output logic              o_last
);

   typedef enum logic [3:0] {
      S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3,
      S_CAP, S_ISSUE, S_WAIT, S_OUT, S_DONE
   } state_t;

   localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

   state_t            r_state;
   logic [DIM_W-1:0]  r_x, r_y, r_w, r_h, r_stride;
   logic [ADDR_W-1:0] r_row_base, r_mem_addr;
   logic [SHW-1:0]    r_s0, r_s1, r_s2, r_s3;
   logic [DATA_W-1:0] r_v00, r_v01, r_v10, r_v11, r_o_data;
   logic              r_busy, r_done, r_mem_req, r_dp_valid;
   logic              r_o_valid, r_o_last;

   logic              w_x_last, w_y_last;
   logic [DIM_W-1:0]  w_x1;
   logic [ADDR_W-1:0] w_x_a, w_x1_a, w_stride_a, w_row1;

   // Edge clamp: the +1 neighbour collapses onto the current sample
   assign w_x_last   = (r_x == r_w - ONE);
   assign w_y_last   = (r_y == r_h - ONE);
   assign w_x1       = w_x_last ? r_x : r_x + ONE;
   assign w_x_a      = ADDR_W'(r_x);
   assign w_x1_a     = ADDR_W'(w_x1);
   assign w_stride_a = ADDR_W'(r_stride);
   assign w_row1     = w_y_last ? r_row_base : r_row_base + w_stride_a;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_x        <= '0;
         r_y        <= '0;
         r_w        <= '0;
         r_h        <= '0;
         r_stride   <= '0;
         r_row_base <= '0;
         r_mem_addr <= '0;
         r_s0       <= '0;
         r_s1       <= '0;
         r_s2       <= '0;
         r_s3       <= '0;
         r_v00      <= '0;
         r_v01      <= '0;
         r_v10      <= '0;
         r_v11      <= '0;
         r_o_data   <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_mem_req  <= 1'b0;
         r_dp_valid <= 1'b0;
         r_o_valid  <= 1'b0;
         r_o_last   <= 1'b0;
      end else if (abort) begin
         r_state    <= S_IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_mem_req  <= 1'b0;
         r_dp_valid <= 1'b0;
         r_o_valid  <= 1'b0;
         r_o_last   <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_w        <= cfg_width;
                  r_h        <= cfg_height;
                  r_stride   <= cfg_stride;
                  r_s0       <= cfg_s0;
                  r_s1       <= cfg_s1;
                  r_s2       <= cfg_s2;
                  r_s3       <= cfg_s3;
                  r_x        <= '0;
                  r_y        <= '0;
                  r_row_base <= cfg_base;
                  if (cfg_width == '0 || cfg_height == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state    <= S_RD0;
                     r_busy     <= 1'b1;
                     r_mem_req  <= 1'b1;
                     r_mem_addr <= cfg_base;
                  end
               end
            end
            S_RD0: begin
               r_mem_addr <= r_row_base + w_x1_a;
               r_state    <= S_RD1;
            end
            S_RD1: begin
               r_v00      <= mem_rdata;
               r_mem_addr <= w_row1 + w_x_a;
               r_state    <= S_RD2;
            end
            S_RD2: begin
               r_v01      <= mem_rdata;
               r_mem_addr <= w_row1 + w_x1_a;
               r_state    <= S_RD3;
            end
            S_RD3: begin
               r_v10     <= mem_rdata;
               r_mem_req <= 1'b0;
               r_state   <= S_CAP;
            end
            S_CAP: begin
               r_v11      <= mem_rdata;
               r_dp_valid <= 1'b1;
               r_state    <= S_ISSUE;
            end
            S_ISSUE: begin
               r_dp_valid <= 1'b0;
               r_state    <= S_WAIT;
            end
            S_WAIT: begin
               if (dp_valid_out) begin
                  r_o_data  <= dp_out;
                  r_o_valid <= 1'b1;
                  r_o_last  <= w_x_last && w_y_last;
                  r_state   <= S_OUT;
               end
            end
            S_OUT: begin
               if (o_ready) begin
                  r_o_valid <= 1'b0;
                  r_o_last  <= 1'b0;
                  if (w_x_last && w_y_last) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state   <= S_RD0;
                     r_mem_req <= 1'b1;
                     if (w_x_last) begin
                        r_x        <= '0;
                        r_y        <= r_y + ONE;
                        r_row_base <= r_row_base + w_stride_a;
                        r_mem_addr <= r_row_base + w_stride_a;
                     end else begin
                        r_x        <= w_x1;
                        r_mem_addr <= r_row_base + w_x1_a;
                     end
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign mem_req     = r_mem_req;
   assign mem_addr    = r_mem_addr;
   assign dp_valid_in = r_dp_valid;
   assign dp_v00      = r_v00;
   assign dp_v01      = r_v01;
   assign dp_v10      = r_v10;
   assign dp_v11      = r_v11;
   assign dp_s0       = r_s0;
   assign dp_s1       = r_s1;
   assign dp_s2       = r_s2;
   assign dp_s3       = r_s3;
   assign o_valid     = r_o_valid;
   assign o_data      = r_o_data;
   assign o_last      = r_o_last;

endmodule

// File: tb/tb_sbilinear_sched.sv
// Directed bench for sbilinear_sched with RAM and
// shift-sum datapath models.
module tb_sbilinear_sched;
   localparam int DW  = 16;
   localparam int SW  = 6;
   localparam int AW  = 12;
   localparam int DMW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0, abort = 1'b0;
   logic [AW-1:0] cfg_base = '0;
   logic [DMW-1:0] cfg_stride = '0, cfg_width = '0, cfg_height = '0;
   logic [SW-1:0] cfg_s0 = '0, cfg_s1 = '0, cfg_s2 = '0, cfg_s3 = '0;
   logic busy, done, mem_req, dp_valid_in, o_valid, o_last;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata = '0;
   logic [DW-1:0] dp_v00, dp_v01, dp_v10, dp_v11, o_data;
   logic [SW-1:0] dp_s0, dp_s1, dp_s2, dp_s3;
   logic [DW-1:0] dp_out = '0;
   logic dp_valid_out = 1'b0;
   logic o_ready = 1'b1;

   always #5 clk = ~clk;

   sbilinear_sched #(.DATA_W(DW), .SHW(SW), .ADDR_W(AW), .DIM_W(DMW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cfg_base(cfg_base), .cfg_stride(cfg_stride),
      .cfg_width(cfg_width), .cfg_height(cfg_height),
      .cfg_s0(cfg_s0), .cfg_s1(cfg_s1), .cfg_s2(cfg_s2), .cfg_s3(cfg_s3),
      .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .dp_valid_in(dp_valid_in),
      .dp_v00(dp_v00), .dp_v01(dp_v01), .dp_v10(dp_v10), .dp_v11(dp_v11),
      .dp_s0(dp_s0), .dp_s1(dp_s1), .dp_s2(dp_s2), .dp_s3(dp_s3),
      .dp_out(dp_out), .dp_valid_out(dp_valid_out),
      .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last)
   );

   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) if (mem_req) mem_rdata <= mem[mem_addr];

   // Datapath model: sum of arithmetically shifted samples, adjustable latency
   int dp_delay = 1;
   int dp_cnt = 0;
   logic dp_pend = 1'b0;
   logic signed [DW-1:0] dp_res;
   always @(posedge clk) begin
      dp_valid_out <= 1'b0;
      if (dp_valid_in) begin
         dp_res = ($signed(dp_v00) >>> dp_s0) + ($signed(dp_v01) >>> dp_s1)
                + ($signed(dp_v10) >>> dp_s2) + ($signed(dp_v11) >>> dp_s3);
         if (dp_delay <= 1) begin
            dp_valid_out <= 1'b1;
            dp_out <= dp_res;
         end else begin
            dp_pend = 1'b1;
            dp_cnt = dp_delay - 1;
         end
      end else if (dp_pend) begin
         dp_cnt--;
         if (dp_cnt == 0) begin
            dp_pend = 1'b0;
            dp_valid_out <= 1'b1;
            dp_out <= dp_res;
         end
      end
   end

   int n_req = 0, n_dpi = 0, n_done = 0;
   logic [DW-1:0] q_data[$];
   logic q_last[$];
   int q_addr[$];
   always @(posedge clk) begin
      if (mem_req) begin
         n_req++;
         q_addr.push_back(int'(mem_addr));
      end
      if (dp_valid_in) n_dpi++;
      if (done) n_done++;
      if (o_valid && o_ready) begin
         q_data.push_back(o_data);
         q_last.push_back(o_last);
      end
   end

   int ncmp = 0, nfail = 0;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic go(input int base, input int stride, input int w,
                     input int h, input int s0, input int s1,
                     input int s2, input int s3);
      @(negedge clk);
      cfg_base = AW'(base);
      cfg_stride = DMW'(stride);
      cfg_width = DMW'(w);
      cfg_height = DMW'(h);
      cfg_s0 = SW'(s0);
      cfg_s1 = SW'(s1);
      cfg_s2 = SW'(s2);
      cfg_s3 = SW'(s3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int snap, input string tag);
      int k = 0;
      while (n_done == snap && k < 400) begin
         @(negedge clk);
         k++;
      end
      check(tag, 32'(n_done != snap), 1);
   endtask

   task automatic check_outs(input string tag, input int q0,
                             input int e0, input int e1,
                             input int e2, input int e3, input int n);
      int e[4];
      e = '{e0, e1, e2, e3};
      check({tag, "_count"}, q_data.size() - q0, n);
      for (int i = 0; i < n; i++) begin
         if (q0 + i < q_data.size()) begin
            check({tag, "_data"}, $signed(q_data[q0+i]), e[i]);
            check({tag, "_last"}, 32'(q_last[q0+i]), (i == n - 1) ? 1 : 0);
         end else begin
            check({tag, "_missing"}, 0, 1);
         end
      end
   endtask

   initial begin
      int q0, d0, r0, a0, p0, k;
      int ea[16];
      for (int i = 0; i < 8; i++) mem[i] = DW'(16 * (i + 1));
      mem[5] = -16'sd64;
      for (int i = 0; i < 4; i++) mem[100+i] = DW'(8 * (i + 1));
      for (int i = 0; i < 3; i++) mem[200+i] = DW'(4 * (i + 1));

      // Reset
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_mem_req", 32'(mem_req), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_dp_valid", 32'(dp_valid_in), 0);
      check("rst_o_valid", 32'(o_valid), 0);
      check("rst_o_last", 32'(o_last), 0);
      check("rst_o_data", 32'(o_data), 0);
      check("rst_dp_v00", 32'(dp_v00), 0);
      check("rst_dp_s0", 32'(dp_s0), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: 2x2 tile
      q0 = q_data.size(); d0 = n_done; a0 = q_addr.size();
      go(0, 2, 2, 2, 2, 2, 2, 2);
      check("t1_busy", 32'(busy), 1);
      wait_done(d0, "t1_done_seen");
      repeat (3) @(negedge clk);
      check("t1_busy_after", 32'(busy), 0);
      check("t1_done_cnt", n_done - d0, 1);
      check_outs("t1", q0, 40, 48, 56, 64, 4);
      ea = '{0, 1, 2, 3, 1, 1, 3, 3, 2, 3, 2, 3, 3, 3, 3, 3};
      check("t1_addr_cnt", q_addr.size() - a0, 16);
      for (int i = 0; i < 16; i++)
         if (a0 + i < q_addr.size()) check("t1_addr", q_addr[a0+i], ea[i]);

      // 2: backpressure on pixel 1
      q0 = q_data.size(); d0 = n_done;
      go(0, 2, 2, 2, 2, 2, 2, 2);
      k = 0;
      while (q_data.size() < q0 + 1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      o_ready = 1'b0;
      k = 0;
      while (o_valid !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      r0 = n_req;
      for (int i = 0; i < 5; i++) begin
         check("t2_stall_valid", 32'(o_valid), 1);
         check("t2_stall_data", 32'(o_data), 48);
         @(negedge clk);
      end
      check("t2_stall_noreq", n_req - r0, 0);
      o_ready = 1'b1;
      wait_done(d0, "t2_done_seen");
      repeat (2) @(negedge clk);
      check("t2_done_cnt", n_done - d0, 1);
      check_outs("t2", q0, 40, 48, 56, 64, 4);

      // 3: zero-size job
      d0 = n_done; r0 = n_req; p0 = n_dpi;
      go(0, 2, 0, 3, 0, 0, 0, 0);
      check("t3_done_pulse", 32'(done), 1);
      repeat (3) @(negedge clk);
      check("t3_done_cnt", n_done - d0, 1);
      check("t3_no_req", n_req - r0, 0);
      check("t3_no_issue", n_dpi - p0, 0);
      check("t3_busy", 32'(busy), 0);

      // 4: abort in WAIT of pixel 2, slow datapath
      q0 = q_data.size(); d0 = n_done;
      dp_delay = 3;
      go(100, 4, 4, 1, 0, 0, 0, 0);
      k = 0;
      while (q_data.size() < q0 + 2 && k < 300) begin
         @(negedge clk);
         k++;
      end
      k = 0;
      while (dp_valid_in !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("t4_issue_seen", 32'(dp_valid_in), 1);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t4_busy", 32'(busy), 0);
      check("t4_o_valid", 32'(o_valid), 0);
      check("t4_mem_req", 32'(mem_req), 0);
      check("t4_dp_valid", 32'(dp_valid_in), 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("t4_late_o_valid", 32'(o_valid), 0);
      end
      check("t4_no_done", n_done - d0, 0);
      check("t4_outs", q_data.size() - q0, 2);
      dp_delay = 1;
      q0 = q_data.size(); d0 = n_done;
      go(100, 4, 4, 1, 0, 0, 0, 0);
      wait_done(d0, "t4b_done_seen");
      repeat (2) @(negedge clk);
      check("t4b_done_cnt", n_done - d0, 1);
      check_outs("t4b", q0, 48, 80, 112, 128, 4);

      // 5: start while busy
      q0 = q_data.size(); d0 = n_done;
      go(200, 4, 3, 1, 0, 0, 0, 0);
      repeat (8) @(negedge clk);
      go(0, 2, 1, 1, 2, 2, 2, 2);
      wait_done(d0, "t5_done_seen");
      repeat (12) @(negedge clk);
      check("t5_done_cnt", n_done - d0, 1);
      check_outs("t5", q0, 24, 40, 48, 0, 3);

      // 6: signed 1x1 with full clamp
      q0 = q_data.size(); d0 = n_done; a0 = q_addr.size();
      go(5, 2, 1, 1, 1, 2, 3, 6);
      wait_done(d0, "t6_done_seen");
      repeat (2) @(negedge clk);
      check("t6_addr_cnt", q_addr.size() - a0, 4);
      for (int i = 0; i < 4; i++)
         if (a0 + i < q_addr.size()) check("t6_addr", q_addr[a0+i], 5);
      check_outs("t6", q0, -57, 0, 0, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
